hex_segment_reader: RTL and testbench

- Decodes a multiplexed 4-digit, active-low seven-segment bus back into hex nibbles. It is the receive-side counterpart of the team's nibble-to-segment encoder.
- It samples the segment and anode lines and waits for each pattern to be stable. It then stores one nibble per digit and flags blank or illegal patterns.
- It sits between an external display bus, or a display driver under test, and the debug/register fabric. Its main uses are self-check of display output and scraping legacy boards.

---
 rtl/seg_pkg.sv | 111 +++++++++++
 rtl/seg_sync.sv | 34 +++
 rtl/hex_segment_reader.sv | 190 +++++++++++++++++++
 tb/tb_hex_segment_reader.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// ============================================================================
// Module   : seg_pkg
// Desc     : Shared seven-segment codes, FSM state type and decode helpers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_pkg;

   // Active-low patterns, bit 6 = g ... bit 0 = a
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      HELD  = 2'd2
   } state_t;

   typedef struct packed {
      logic       err;
      logic       blank;
      logic [3:0] nibble;
   } seg_dec_t;

   function automatic seg_dec_t seg_decode(input logic [6:0] pat);
      seg_dec_t d;
      d.err    = 1'b0;
      d.blank  = 1'b0;
      d.nibble = 4'h0;
      case (pat)
         SEG_0:     d.nibble = 4'h0;
         SEG_1:     d.nibble = 4'h1;
         SEG_2:     d.nibble = 4'h2;
         SEG_3:     d.nibble = 4'h3;
         SEG_4:     d.nibble = 4'h4;
         SEG_5:     d.nibble = 4'h5;
         SEG_6:     d.nibble = 4'h6;
         SEG_7:     d.nibble = 4'h7;
         SEG_8:     d.nibble = 4'h8;
         SEG_9:     d.nibble = 4'h9;
         SEG_A:     d.nibble = 4'hA;
         SEG_B:     d.nibble = 4'hB;
         SEG_C:     d.nibble = 4'hC;
         SEG_D:     d.nibble = 4'hD;
         SEG_E:     d.nibble = 4'hE;
         SEG_F:     d.nibble = 4'hF;
         SEG_BLANK: d.blank  = 1'b1;
         default:   d.err    = 1'b1;
      endcase
      return d;
   endfunction

   // Encoder-side mapping, kept beside the decoder so both use one table
   function automatic logic [6:0] seg_encode(input logic [3:0] nib);
      logic [6:0] p;
      case (nib)
         4'h0:    p = SEG_0;
         4'h1:    p = SEG_1;
         4'h2:    p = SEG_2;
         4'h3:    p = SEG_3;
         4'h4:    p = SEG_4;
         4'h5:    p = SEG_5;
         4'h6:    p = SEG_6;
         4'h7:    p = SEG_7;
         4'h8:    p = SEG_8;
         4'h9:    p = SEG_9;
         4'hA:    p = SEG_A;
         4'hB:    p = SEG_B;
         4'hC:    p = SEG_C;
         4'hD:    p = SEG_D;
         4'hE:    p = SEG_E;
         default: p = SEG_F;
      endcase
      return p;
   endfunction

   function automatic logic an_sel_ok(input logic [3:0] an);
      return $onehot(~an);
   endfunction

   function automatic logic [1:0] an_sel_idx(input logic [3:0] an);
      logic [1:0] idx;
      case (an)
         4'b1110: idx = 2'd0;
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

endpackage

`default_nettype wire

// File: rtl/seg_sync.sv
// ============================================================================
// Module   : seg_sync
// Desc     : Two-flop synchronizer, resets to all-ones (idle display bus).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_sync #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= '1;
         r_sync <= '1;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/hex_segment_reader.sv
// ============================================================================
// Module   : hex_segment_reader
// Desc     : Recovers hex nibbles from a multiplexed 4-digit active-low
//            seven-segment bus after a stability window.
// Options  : HEX_SEGMENT_READER_DP_EN adds dp input and dps output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_segment_reader
   import seg_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  seg,
   input  logic [3:0]  an,
`ifdef HEX_SEGMENT_READER_DP_EN
   input  logic        dp,
   output logic [3:0]  dps,
`endif
   output logic [15:0] digits,
   output logic [3:0]  blank,
   output logic [3:0]  err,
   output logic        upd,
   output logic [1:0]  upd_idx
);

   // Out-of-range settings are clamped to the legal 1..255 window
   localparam int         c_stable_i = (STABLE_CYCLES < 1)   ? 1   :
                                       (STABLE_CYCLES > 255) ? 255 : STABLE_CYCLES;
   localparam logic [7:0] c_stable   = 8'(c_stable_i);

`ifdef HEX_SEGMENT_READER_DP_EN
   localparam int c_sw = 12;
   logic [c_sw-1:0] w_raw;
   assign w_raw = {an, dp, seg};
`else
   localparam int c_sw = 11;
   logic [c_sw-1:0] w_raw;
   assign w_raw = {an, seg};
`endif

   logic [c_sw-1:0] w_s;
   logic [3:0]      w_an_s;
   logic [6:0]      w_seg_s;

   seg_sync #(
      .WIDTH (c_sw)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (w_raw),
      .o_q   (w_s)
   );

   assign w_an_s  = w_s[c_sw-1 -: 4];
   assign w_seg_s = w_s[6:0];

   state_t          r_state;
   state_t          w_state_nxt;
   logic [7:0]      r_cnt;
   logic [7:0]      w_cnt_nxt;
   logic [c_sw-1:0] r_last;
   logic            w_same;
   logic            w_sel;
   logic            w_cap;

   assign w_same = (w_s == r_last);
   assign w_sel  = an_sel_ok(w_an_s);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= 8'd0;
         r_last  <= '1;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_last  <= w_s;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_cap       = 1'b0;
      case (r_state)
         IDLE: begin
            w_cnt_nxt = 8'd0;
            if (w_sel) begin
               w_state_nxt = COUNT;
               w_cnt_nxt   = 8'd1;
            end
         end
         COUNT: begin
            if (!w_sel) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = 8'd0;
            end else if (!w_same) begin
               w_cnt_nxt   = 8'd1;
            end else if (r_cnt >= c_stable) begin
               // Window complete: cnt stays saturated while the digit is held
               w_cap       = 1'b1;
               w_state_nxt = HELD;
               w_cnt_nxt   = c_stable;
            end else begin
               w_cnt_nxt   = r_cnt + 8'd1;
            end
         end
         HELD: begin
            if (!w_same) begin
               if (w_sel) begin
                  w_state_nxt = COUNT;
                  w_cnt_nxt   = 8'd1;
               end else begin
                  w_state_nxt = IDLE;
                  w_cnt_nxt   = 8'd0;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 8'd0;
         end
      endcase
   end

   seg_dec_t   w_dec;
   logic [1:0] w_idx;

   assign w_dec = seg_decode(w_seg_s);
   assign w_idx = an_sel_idx(w_an_s);

   logic [15:0] r_digits;
   logic [3:0]  r_blank;
   logic [3:0]  r_err;
   logic        r_upd;
   logic [1:0]  r_upd_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_digits  <= 16'h0000;
         r_blank   <= 4'hF;
         r_err     <= 4'h0;
         r_upd     <= 1'b0;
         r_upd_idx <= 2'd0;
      end else begin
         r_upd <= w_cap;
         if (w_cap) begin
            r_upd_idx <= w_idx;
            for (int i = 0; i < 4; i++) begin
               if (w_idx == 2'(i)) begin
                  r_digits[4*i +: 4] <= w_dec.nibble;
                  r_blank[i]         <= w_dec.blank;
                  r_err[i]           <= w_dec.err;
               end
            end
         end
      end
   end

`ifdef HEX_SEGMENT_READER_DP_EN
   logic [3:0] r_dps;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dps <= 4'h0;
      end else if (w_cap) begin
         for (int i = 0; i < 4; i++) begin
            if (w_idx == 2'(i)) begin
               r_dps[i] <= ~w_s[7];
            end
         end
      end
   end

   assign dps = r_dps;
`endif

   assign digits  = r_digits;
   assign blank   = r_blank;
   assign err     = r_err;
   assign upd     = r_upd;
   assign upd_idx = r_upd_idx;

endmodule

`default_nettype wire

// File: tb/tb_hex_segment_reader.sv
// ============================================================================
// Module   : tb_hex_segment_reader
// Desc     : Directed self-checking bench for hex_segment_reader (STABLE_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hex_segment_reader;

   logic        clk;
   logic        rst_n;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic [15:0] digits;
   logic [3:0]  blank;
   logic [3:0]  err;
   logic        upd;
   logic [1:0]  upd_idx;

   int checks   = 0;
   int failures = 0;

   int         upd_seen = 0;
   int         dbl      = 0;
   logic       prev_upd = 1'b0;
   logic [1:0] idx_log[$];

   hex_segment_reader #(
      .STABLE_CYCLES (4)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .seg     (seg),
      .an      (an),
      .digits  (digits),
      .blank   (blank),
      .err     (err),
      .upd     (upd),
      .upd_idx (upd_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (upd) begin
         upd_seen++;
         idx_log.push_back(upd_idx);
      end
      if (upd && prev_upd) dbl++;
      prev_upd = upd;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      an    = 4'hF;
      seg   = 7'h7F;
      tick(3);
      checks++; if (digits !== 16'h0000) begin failures++; $display("FAIL reset_digits got=%h exp=%h", digits, 16'h0000); end
      checks++; if (blank !== 4'hF) begin failures++; $display("FAIL reset_blank got=%h exp=%h", blank, 4'hF); end
      checks++; if (err !== 4'h0) begin failures++; $display("FAIL reset_err got=%h exp=%h", err, 4'h0); end
      checks++; if (upd !== 1'b0) begin failures++; $display("FAIL reset_upd got=%b exp=0", upd); end
      rst_n = 1'b1;
      tick(10);
      checks++; if (upd_seen !== 0) begin failures++; $display("FAIL idle_no_upd got=%0d exp=0", upd_seen); end
   endtask

   task automatic test_stable_digit;
      upd_seen = 0;
      idx_log.delete();
      an  = 4'hE;
      seg = 7'h30;
      tick(6);
      checks++; if (upd !== 1'b0) begin failures++; $display("FAIL stable_early_upd got=%b exp=0", upd); end
      tick(1);
      checks++; if (upd !== 1'b1) begin failures++; $display("FAIL stable_upd got=%b exp=1", upd); end
      checks++; if (upd_idx !== 2'd0) begin failures++; $display("FAIL stable_idx got=%0d exp=0", upd_idx); end
      checks++; if (digits[3:0] !== 4'h3) begin failures++; $display("FAIL stable_nibble got=%h exp=3", digits[3:0]); end
      checks++; if (blank !== 4'hE) begin failures++; $display("FAIL stable_blank got=%h exp=e", blank); end
      tick(1);
      checks++; if (upd !== 1'b0) begin failures++; $display("FAIL stable_upd_fall got=%b exp=0", upd); end
      tick(6);
      checks++; if (upd_seen !== 1) begin failures++; $display("FAIL stable_count got=%0d exp=1", upd_seen); end
   endtask

   task automatic test_glitch;
      upd_seen = 0;
      seg = 7'h19;
      tick(3);
      seg = 7'h24;
      tick(12);
      checks++; if (upd_seen !== 1) begin failures++; $display("FAIL glitch_count got=%0d exp=1", upd_seen); end
      checks++; if (digits[3:0] !== 4'h2) begin failures++; $display("FAIL glitch_nibble got=%h exp=2", digits[3:0]); end
   endtask

   task automatic test_scan;
      logic [3:0] an_tab [4];
      logic [6:0] seg_tab[4];
      an_tab  = '{4'hE, 4'hD, 4'hB, 4'h7};
      seg_tab = '{7'h21, 7'h46, 7'h06, 7'h7F};
      upd_seen = 0;
      idx_log.delete();
      for (int k = 0; k < 4; k++) begin
         an  = an_tab[k];
         seg = seg_tab[k];
         tick(8);
      end
      checks++; if (digits !== 16'h0ECD) begin failures++; $display("FAIL scan_digits got=%h exp=%h", digits, 16'h0ECD); end
      checks++; if (blank !== 4'h8) begin failures++; $display("FAIL scan_blank got=%h exp=8", blank); end
      checks++; if (err !== 4'h0) begin failures++; $display("FAIL scan_err got=%h exp=0", err); end
      checks++; if (upd_seen !== 4) begin failures++; $display("FAIL scan_count got=%0d exp=4", upd_seen); end
      if (idx_log.size() == 4) begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (idx_log[k] !== 2'(k)) begin failures++; $display("FAIL scan_idx%0d got=%0d exp=%0d", k, idx_log[k], k); end
         end
      end
   endtask

   task automatic test_illegal;
      upd_seen = 0;
      an  = 4'hB;
      seg = 7'h55;
      tick(10);
      checks++; if (err !== 4'h4) begin failures++; $display("FAIL illegal_err got=%h exp=4", err); end
      checks++; if (digits !== 16'h00CD) begin failures++; $display("FAIL illegal_digits got=%h exp=%h", digits, 16'h00CD); end
      checks++; if (blank !== 4'h8) begin failures++; $display("FAIL illegal_blank got=%h exp=8", blank); end
      checks++; if (upd_seen !== 1) begin failures++; $display("FAIL illegal_count got=%0d exp=1", upd_seen); end
   endtask

   task automatic test_multi_select;
      upd_seen = 0;
      an  = 4'hC;
      seg = 7'h40;
      tick(10);
      checks++; if (upd_seen !== 0) begin failures++; $display("FAIL multi_count got=%0d exp=0", upd_seen); end
      checks++; if (digits !== 16'h00CD) begin failures++; $display("FAIL multi_digits got=%h exp=%h", digits, 16'h00CD); end
      checks++; if (err !== 4'h4) begin failures++; $display("FAIL multi_err got=%h exp=4", err); end
   endtask

   task automatic test_back_to_back;
      upd_seen = 0;
      idx_log.delete();
      an = 4'hE; seg = 7'h21; tick(8);
      an = 4'hD; seg = 7'h46; tick(8);
      an = 4'hE; seg = 7'h21; tick(8);
      checks++; if (upd_seen !== 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", upd_seen); end
      checks++; if (digits !== 16'h00CD) begin failures++; $display("FAIL b2b_digits got=%h exp=%h", digits, 16'h00CD); end
      if (idx_log.size() == 3) begin
         checks++; if (idx_log[2] !== 2'd0) begin failures++; $display("FAIL b2b_idx got=%0d exp=0", idx_log[2]); end
      end
      checks++; if (dbl !== 0) begin failures++; $display("FAIL upd_double got=%0d exp=0", dbl); end
   endtask

   task automatic test_reset_mid;
      upd_seen = 0;
      an  = 4'hB;
      seg = 7'h12;
      tick(4);
      rst_n = 1'b0;
      #1;
      checks++; if (digits !== 16'h0000) begin failures++; $display("FAIL mid_digits got=%h exp=0000", digits); end
      checks++; if (blank !== 4'hF) begin failures++; $display("FAIL mid_blank got=%h exp=f", blank); end
      checks++; if (err !== 4'h0) begin failures++; $display("FAIL mid_err got=%h exp=0", err); end
      checks++; if (upd !== 1'b0) begin failures++; $display("FAIL mid_upd got=%b exp=0", upd); end
      tick(2);
      rst_n = 1'b1;
      tick(6);
      checks++; if (upd_seen !== 0) begin failures++; $display("FAIL mid_early_count got=%0d exp=0", upd_seen); end
      tick(1);
      checks++; if (upd !== 1'b1) begin failures++; $display("FAIL mid_fresh_upd got=%b exp=1", upd); end
      checks++; if (digits !== 16'h0500) begin failures++; $display("FAIL mid_fresh_digits got=%h exp=0500", digits); end
      checks++; if (blank !== 4'hB) begin failures++; $display("FAIL mid_fresh_blank got=%h exp=b", blank); end
   endtask

   initial begin
      rst_n = 1'b0;
      an    = 4'hF;
      seg   = 7'h7F;
      test_reset();
      test_stable_digit();
      test_glitch();
      test_scan();
      test_illegal();
      test_multi_select();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
